bus_frame_receiver: RTL and testbench

//  Receive end of the single-wire serial bus driven by the 16-node FPGA transmitter (bus_out).

---
 rtl/bus_frame_receiver_if.sv | 28 ++
 rtl/bus_frame_receiver.sv | 148 ++++++++++++++
 tb/tb_bus_frame_receiver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_frame_receiver_if.sv
// Serial bus line plus the deframed outputs of one node's receiver.
// master drives the bus line and observes results; slave is the receiver itself.
interface bus_frame_receiver_if #(
   parameter int DATA_W = 64,
   parameter int MOD_W  = 2,
   parameter int CRC_W  = 4
);
   // rx_valid and crc_err are single-cycle strobes with no back-pressure:
   // there is no ready, so the consumer must capture rx_* in the strobe cycle
   // (rx_data/rx_mod/rx_crc also hold until the next qualifying frame).
   logic              bus_in;
   logic [DATA_W-1:0] rx_data;
   logic [MOD_W-1:0]  rx_mod;
   logic [CRC_W-1:0]  rx_crc;
   logic              rx_valid;
   logic              crc_err;
   logic              rx_busy;

   modport master (
      output bus_in,
      input  rx_data, rx_mod, rx_crc, rx_valid, crc_err, rx_busy
   );

   modport slave (
      input  bus_in,
      output rx_data, rx_mod, rx_crc, rx_valid, crc_err, rx_busy
   );
endinterface

// File: rtl/bus_frame_receiver.sv
// Deframes start/addr/mod/data/crc from the single-wire bus, one bit per clock,
// and presents frames addressed to MY_ADDR after a CRC-4 (x^4+x+1) check.
module bus_frame_receiver #(
   parameter int unsigned MY_ADDR = 1,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 4,
   parameter int MOD_W  = 2,
   parameter int CRC_W  = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   bus_frame_receiver_if.slave  bus,
   output logic [2:0]           fsm_state
);

   localparam int FRAME_W = ADDR_W + MOD_W + DATA_W + CRC_W;
   localparam int CNT_W   = $clog2(FRAME_W);
   localparam logic [CRC_W-1:0] CRC_POLY = CRC_W'(3);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      MOD  = 3'd2,
      DATA = 3'd3,
      CRC  = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [CRC_W-1:0]   crc_q, crc_nxt;
   logic [FRAME_W-2:0] frame_sr;
   logic               crc_en;
   logic               start;
   logic               done;
   logic               fb;

   // The last crc bit is still on bus_in at the completion edge.
   logic [FRAME_W-1:0] full;
   logic [ADDR_W-1:0]  addr_f;
   logic [MOD_W-1:0]   mod_f;
   logic [DATA_W-1:0]  data_f;
   logic [CRC_W-1:0]   crc_f;

   assign full   = {frame_sr, bus.bus_in};
   assign addr_f = full[FRAME_W-1 -: ADDR_W];
   assign mod_f  = full[CRC_W+DATA_W +: MOD_W];
   assign data_f = full[CRC_W +: DATA_W];
   assign crc_f  = full[CRC_W-1:0];

   assign fb      = crc_q[CRC_W-1] ^ bus.bus_in;
   assign crc_nxt = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      crc_en    = 1'b0;
      start     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.bus_in) begin
               start     = 1'b1;
               state_nxt = ADDR;
               cnt_nxt   = CNT_W'(ADDR_W - 1);
            end
         end
         ADDR: begin
            crc_en = 1'b1;
            if (cnt == '0) begin
               state_nxt = MOD;
               cnt_nxt   = CNT_W'(MOD_W - 1);
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         MOD: begin
            crc_en = 1'b1;
            if (cnt == '0) begin
               state_nxt = DATA;
               cnt_nxt   = CNT_W'(DATA_W - 1);
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         DATA: begin
            crc_en = 1'b1;
            if (cnt == '0) begin
               state_nxt = CRC;
               cnt_nxt   = CNT_W'(CRC_W - 1);
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         CRC: begin
            if (cnt == '0) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         crc_q        <= '0;
         frame_sr     <= '0;
         bus.rx_data  <= '0;
         bus.rx_mod   <= '0;
         bus.rx_crc   <= '0;
         bus.rx_valid <= 1'b0;
         bus.crc_err  <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         bus.rx_valid <= 1'b0;
         bus.crc_err  <= 1'b0;
         if (start) begin
            crc_q    <= '0;
            frame_sr <= '0;
         end else if (state != IDLE) begin
            frame_sr <= {frame_sr[FRAME_W-3:0], bus.bus_in};
         end
         if (crc_en) begin
            crc_q <= crc_nxt;
         end
         // Foreign frames fall through here untouched: no strobe, outputs held.
         if (done && (addr_f == ADDR_W'(MY_ADDR))) begin
            bus.rx_crc <= crc_f;
            if (crc_f == crc_q) begin
               bus.rx_valid <= 1'b1;
               bus.rx_data  <= data_f;
               bus.rx_mod   <= mod_f;
            end else begin
               bus.crc_err <= 1'b1;
            end
         end
      end
   end

   assign bus.rx_busy = (state != IDLE);
   assign fsm_state   = state;

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Directed frames into bus_frame_receiver (MY_ADDR=1); a monitor pops the
// expected strobe contents from exp_q whenever rx_valid or crc_err is seen.
module tb_bus_frame_receiver;

   localparam int DATA_W = 64;
   localparam int EXP_W  = 1 + DATA_W + 2 + 4;  // {is_err, data, mod, crc}

   logic       clock;
   logic       reset_n;
   logic [2:0] fsm_state;

   bus_frame_receiver_if #(.DATA_W(DATA_W), .MOD_W(2), .CRC_W(4)) bus ();

   bus_frame_receiver #(
      .MY_ADDR(1), .DATA_W(DATA_W), .ADDR_W(4), .MOD_W(2), .CRC_W(4)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   logic [EXP_W-1:0] exp_q[$];
   int pulse_t[$];
   logic [DATA_W-1:0] model_data = '0;
   logic [1:0]        model_mod  = '0;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clock) begin
      logic [EXP_W-1:0] e;
      if (reset_n && (bus.rx_valid || bus.crc_err)) begin
         check("strobe_exclusive", {bus.rx_valid, bus.crc_err}, (bus.rx_valid ? 2'b10 : 2'b01));
         if (bus.rx_valid) pulse_t.push_back(cycle);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {bus.rx_valid, bus.crc_err}, 2'b00);
         end else begin
            e = exp_q.pop_front();
            check("strobe_kind", {bus.crc_err, bus.rx_valid}, {e[EXP_W-1], ~e[EXP_W-1]});
            check("rx_data", bus.rx_data, e[6 +: DATA_W]);
            check("rx_mod",  bus.rx_mod,  e[5:4]);
            check("rx_crc",  bus.rx_crc,  e[3:0]);
         end
      end
   end

   // ---------------- model + drivers ----------------
   function automatic logic [3:0] crc4(input logic [3:0] a, input logic [1:0] m, input logic [63:0] d);
      logic [69:0] msg;
      logic [3:0]  c;
      logic        f;
      msg = {a, m, d};
      c   = 4'h0;
      for (int i = 69; i >= 0; i--) begin
         f = c[3] ^ msg[i];
         c = {c[2:0], 1'b0} ^ (f ? 4'b0011 : 4'b0000);
      end
      return c;
   endfunction

   task automatic idle(input int n);
      bus.bus_in = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Drives nbits of the frame (75 = complete); pushes the expectation only
   // for frames that complete. check_busy verifies rx_busy across the frame.
   task automatic send_frame(input logic [3:0] a, input logic [1:0] m,
                             input logic [63:0] d, input logic [3:0] c,
                             input int nbits, input bit check_busy);
      logic [74:0] f;
      f = {1'b1, a, m, d, c};
      if (nbits == 75 && a == 4'd1) begin
         if (c == crc4(a, m, d)) begin
            exp_q.push_back({1'b0, d, m, c});
            model_data = d;
            model_mod  = m;
         end else begin
            exp_q.push_back({1'b1, model_data, model_mod, c});
         end
      end
      for (int i = 0; i < nbits; i++) begin
         bus.bus_in = f[74 - i];
         @(posedge clock);
         #1;
         if (check_busy) begin
            if (i < 74) check("busy_in_frame", bus.rx_busy, 1'b1);
            else        check("busy_after_frame", bus.rx_busy, 1'b0);
         end
      end
      bus.bus_in = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_data"},  bus.rx_data,  '0);
      check({tag, "_mod"},   bus.rx_mod,   '0);
      check({tag, "_crc"},   bus.rx_crc,   '0);
      check({tag, "_valid"}, bus.rx_valid, 1'b0);
      check({tag, "_err"},   bus.crc_err,  1'b0);
      check({tag, "_busy"},  bus.rx_busy,  1'b0);
      check({tag, "_state"}, fsm_state,    3'd0);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      bus.bus_in = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      model_data = '0;
      model_mod  = '0;
      reset_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0;
      int wait_cnt;
      logic [63:0] d2;
      apply_reset();
      check_outputs_zero("reset");

      // 1: addr=1 mod=1 data=1, crc=1 (hand-computed x^70+x^68+x^4 mod P = 1)
      send_frame(4'd1, 2'd1, 64'h1, 4'h1, 75, 1'b0);
      idle(3);
      check("t1_held_data", bus.rx_data, 64'h1);

      // 2: same frame, corrupted crc -> crc_err, data/mod held at 1/1
      send_frame(4'd1, 2'd1, 64'h1, 4'h2, 75, 1'b0);
      idle(3);
      check("t2_rx_crc_updated", bus.rx_crc, 4'h2);
      check("t2_data_held", bus.rx_data, 64'h1);

      // 3: foreign address with a good crc -> silent; busy across the frame
      send_frame(4'd3, 2'd2, 64'h0123_4567_89AB_CDEF, crc4(4'd3, 2'd2, 64'h0123_4567_89AB_CDEF), 75, 1'b1);
      idle(3);
      check("t3_data_held", bus.rx_data, 64'h1);
      check("t3_crc_held", bus.rx_crc, 4'h2);

      // 4: back-to-back valid frames, pulses 75 cycles apart
      pulse_t.delete();
      d2 = 64'hDEADBEEF_0000_0001;
      send_frame(4'd1, 2'd3, 64'hA5A5_0000_FFFF_1234, crc4(4'd1, 2'd3, 64'hA5A5_0000_FFFF_1234), 75, 1'b0);
      send_frame(4'd1, 2'd2, d2, crc4(4'd1, 2'd2, d2), 75, 1'b0);
      idle(3);
      check("t4_pulse_count", pulse_t.size(), 2);
      if (pulse_t.size() == 2) check("t4_pulse_spacing", pulse_t[1] - pulse_t[0], 75);
      check("t4_final_data", bus.rx_data, d2);

      // 5: reset after data bit 29 (start+addr+mod+30 data bits), then a full frame
      send_frame(4'd1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, crc4(4'd1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF), 37, 1'b0);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      repeat (2) @(posedge clock);
      #1;
      model_data = '0;
      model_mod  = '0;
      reset_n = 1'b1;
      idle(2);
      send_frame(4'd1, 2'd1, 64'h1, 4'h1, 75, 1'b0);
      idle(3);
      check("t5_data", bus.rx_data, 64'h1);

      // 6: idle bus after reset stays quiet
      apply_reset();
      for (int i = 0; i < 200; i++) begin
         idle(1);
         if (i % 20 == 0) check_outputs_zero("idle");
      end

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 200) begin
         idle(1);
         wait_cnt++;
      end
      check("pending_expectations", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
